// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU op codes, M-extension
// funct3 values, forwarding selects and the divider FSM states.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
    return c ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle on magnitudes, sign correction applied on the way out.
module serial_divider
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic [31:0] result_o
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic        negq_q, negq_d, negr_q, negr_d, isrem_q, isrem_d;
  logic        busy_c, is_signed, div_zero, div_ovf;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, diff;

  always_comb begin
    is_signed = ~op_i[0];
    abs_a     = neg_if(is_signed & dividend_i[31], dividend_i);
    abs_b     = neg_if(is_signed & divisor_i[31], divisor_i);
    div_zero  = (divisor_i == 32'd0);
    div_ovf   = is_signed && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
    shifted   = {rem_q, quo_q[31]};
    diff      = shifted - {1'b0, dvsr_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isrem_d = isrem_q;
    busy_c  = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          busy_c  = 1'b1;
          isrem_d = op_i[1];
          if (div_zero || div_ovf) begin
            // Result is fixed up front; DONE outputs it with no sign correction.
            quo_d   = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            rem_d   = div_zero ? dividend_i : 32'd0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            cnt_d   = 5'd0;
            state_d = DIV_DONE;
          end else begin
            quo_d   = abs_a;
            rem_d   = 32'd0;
            dvsr_d  = abs_b;
            negq_d  = is_signed & (dividend_i[31] ^ divisor_i[31]);
            negr_d  = is_signed & dividend_i[31];
            cnt_d   = 5'd31;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        busy_c = 1'b1;
        // Trial subtract is non-negative exactly when bit 32 of the difference is clear.
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd0) state_d = DIV_DONE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      // DONE never restarts: the same op is still held in ID/EX this cycle.
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    if (clear_i) begin
      state_d = DIV_IDLE;
      cnt_d   = 5'd0;
    end
  end

  assign busy_o   = busy_c & ~clear_i & ~reset_i;
  assign result_o = isrem_q ? neg_if(negr_q, rem_q) : neg_if(negq_q, quo_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isrem_q <= isrem_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the RV32IM pipeline: operand forwarding, ALU, single-cycle
// multiplier, iterative divider and branch/jump target adder.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cleare,
  input  logic [XLEN-1:0] rd1e,
  input  logic [XLEN-1:0] rd2e,
  input  logic [XLEN-1:0] pce,
  input  logic [XLEN-1:0] immexte,
  input  logic [1:0]      forwardae,
  input  logic [1:0]      forwardbe,
  input  logic [XLEN-1:0] resultw,
  input  logic [XLEN-1:0] aluresultm,
  input  logic            alusrce,
  input  logic [3:0]      alucontrole,
  input  logic            jalre,
  input  logic            mdu_en_e,
  input  logic [2:0]      mdu_op_e,
  output logic [XLEN-1:0] aluresulte,
  output logic [XLEN-1:0] writedatae,
  output logic [XLEN-1:0] pctargete,
  output logic            zeroe,
  output logic            mdu_busye
);

  logic [XLEN-1:0] srca, srcb, fwdb, alu_res, mul_res, div_res, tgt_base, tgt_sum;
  logic            m_en, a_sgn, b_sgn, div_busy;
  logic signed [63:0] mul_a, mul_b, mul_p;

  always_comb begin
    case (forwardae)
      FWD_WB:  srca = resultw;
      FWD_MEM: srca = aluresultm;
      default: srca = rd1e;
    endcase
    case (forwardbe)
      FWD_WB:  fwdb = resultw;
      FWD_MEM: fwdb = aluresultm;
      default: fwdb = rd2e;
    endcase
    srcb = alusrce ? immexte : fwdb;
  end

  assign writedatae = fwdb;

  always_comb begin
    case (alucontrole)
      ALU_ADD:  alu_res = srca + srcb;
      ALU_SUB:  alu_res = srca - srcb;
      ALU_AND:  alu_res = srca & srcb;
      ALU_OR:   alu_res = srca | srcb;
      ALU_XOR:  alu_res = srca ^ srcb;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (srca < srcb)};
      ALU_SLL:  alu_res = srca << srcb[4:0];
      ALU_SRL:  alu_res = srca >> srcb[4:0];
      ALU_SRA:  alu_res = $signed(srca) >>> srcb[4:0];
      default:  alu_res = '0;
    endcase
  end

  // Operands extended to 64 bits so a plain mod-2^64 product is exact for every variant.
  always_comb begin
    a_sgn   = (mdu_op_e == M_MULH) || (mdu_op_e == M_MULHSU);
    b_sgn   = (mdu_op_e == M_MULH);
    mul_a   = {{32{a_sgn & srca[31]}}, srca};
    mul_b   = {{32{b_sgn & srcb[31]}}, srcb};
    mul_p   = mul_a * mul_b;
    mul_res = (mdu_op_e == M_MUL) ? mul_p[31:0] : mul_p[63:32];
  end

  always_comb begin
    tgt_base  = jalre ? srca : pce;
    tgt_sum   = tgt_base + immexte;
    pctargete = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~jalre};
  end

  assign m_en = SUPPORT_M && mdu_en_e;

  generate
    if (SUPPORT_M) begin : g_div
      serial_divider u_div (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (cleare),
        .start_i    (mdu_en_e & mdu_op_e[2]),
        .op_i       (mdu_op_e),
        .dividend_i (srca),
        .divisor_i  (srcb),
        .busy_o     (div_busy),
        .result_o   (div_res)
      );
    end else begin : g_no_div
      assign div_busy = 1'b0;
      assign div_res  = '0;
    end
  endgenerate

  assign mdu_busye  = div_busy;
  assign aluresulte = m_en ? (mdu_op_e[2] ? div_res : mul_res) : alu_res;
  assign zeroe      = (aluresulte == '0);

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with an expected-result scoreboard.
module tb_execute_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cleare, alusrce, jalre, mdu_en_e, zeroe, mdu_busye;
  logic [31:0] rd1e, rd2e, pce, immexte, resultw, aluresultm;
  logic [31:0] aluresulte, writedatae, pctargete;
  logic [1:0]  forwardae, forwardbe;
  logic [3:0]  alucontrole;
  logic [2:0]  mdu_op_e;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  execute_stage #(.XLEN(32), .SUPPORT_M(1'b1)) dut (
    .clk(clk), .reset(reset), .cleare(cleare), .rd1e(rd1e), .rd2e(rd2e),
    .pce(pce), .immexte(immexte), .forwardae(forwardae), .forwardbe(forwardbe),
    .resultw(resultw), .aluresultm(aluresultm), .alusrce(alusrce),
    .alucontrole(alucontrole), .jalre(jalre), .mdu_en_e(mdu_en_e),
    .mdu_op_e(mdu_op_e), .aluresulte(aluresulte), .writedatae(writedatae),
    .pctargete(pctargete), .zeroe(zeroe), .mdu_busye(mdu_busye)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic compare_out(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    rd1e = a; rd2e = b; forwardae = FWD_RF; forwardbe = FWD_RF;
    alusrce = 1'b0; jalre = 1'b0; mdu_en_e = 1'b0; alucontrole = op;
  endtask

  task automatic set_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    set_alu(ALU_ADD, a, b);
    mdu_en_e = 1'b1; mdu_op_e = op;
  endtask

  task automatic div_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    set_mdu(op, a, b);
    expect_val(tag, exp);
  endtask

  task automatic div_finish(input string tag, input int exp_cycles);
    int cycles = 0;
    @(negedge clk);
    while (mdu_busye === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(cycles), 32'(exp_cycles));
    compare_out(aluresulte);
    @(posedge clk); #1;
    mdu_en_e = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cleare = 1'b0; pce = 32'h0; immexte = 32'h0;
    resultw = 32'h0; aluresultm = 32'h0; mdu_op_e = M_DIV;
    set_mdu(M_DIV, 32'd10, 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(mdu_busye), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mdu_en_e = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(mdu_busye), 32'd0);

    // Forwarding paths
    @(posedge clk); #1;
    set_alu(ALU_ADD, 32'd1, 32'd0);
    aluresultm = 32'd5; forwardae = FWD_MEM; alusrce = 1'b1; immexte = 32'd3;
    expect_val("fwd_mem", 32'd8);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    forwardae = FWD_WB; resultw = 32'd7;
    expect_val("fwd_wb", 32'd10);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    forwardae = 2'b11;
    expect_val("fwd_11", 32'd4);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    forwardbe = FWD_MEM; rd2e = 32'd99;
    expect_val("store_data", 32'd5);
    @(negedge clk); compare_out(writedatae);

    // ALU edge cases
    @(posedge clk); #1;
    set_alu(ALU_SRA, 32'h8000_0000, 32'd31);
    expect_val("sra", 32'hFFFF_FFFF);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    set_alu(ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
    expect_val("sltu", 32'd1);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    set_alu(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
    expect_val("slt", 32'd0);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    set_alu(ALU_SUB, 32'd5, 32'd5);
    expect_val("sub", 32'd0);
    @(negedge clk); compare_out(aluresulte);
    chk("sub_zero", 32'(zeroe), 32'd1);
    @(posedge clk); #1;
    set_alu(4'd15, 32'd5, 32'd6);
    expect_val("undef_op", 32'd0);
    @(negedge clk); compare_out(aluresulte);

    // Multiplier and jump target
    @(posedge clk); #1;
    set_mdu(M_MULH, 32'h8000_0000, 32'h8000_0000);
    expect_val("mulh", 32'h4000_0000);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    set_mdu(M_MULHSU, 32'hFFFF_FFFF, 32'd2);
    expect_val("mulhsu", 32'hFFFF_FFFF);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    set_mdu(M_MUL, 32'd1234, 32'hFFFF_FFFE);
    expect_val("mul", 32'hFFFF_F65C);
    @(negedge clk); compare_out(aluresulte);
    @(posedge clk); #1;
    set_alu(ALU_ADD, 32'h101, 32'd0);
    jalre = 1'b1; immexte = 32'd4; pce = 32'h2000;
    expect_val("jalr_target", 32'h104);
    @(negedge clk); compare_out(pctargete);
    @(posedge clk); #1;
    jalre = 1'b0; immexte = 32'h11;
    expect_val("branch_target", 32'h2011);
    @(negedge clk); compare_out(pctargete);

    // Iterative divides
    div_start(M_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", 32'hFFFF_FFFD);
    div_finish("div_neg7_2", 33);
    div_start(M_REM, 32'hFFFF_FFF9, 32'd2, "rem_neg7_2", 32'hFFFF_FFFF);
    div_finish("rem_neg7_2", 33);
    div_start(M_DIVU, 32'd100, 32'd7, "divu_100_7", 32'd14);
    div_finish("divu_100_7", 33);

    // Special cases
    div_start(M_DIV, 32'd42, 32'd0, "div_by0", 32'hFFFF_FFFF);
    div_finish("div_by0", 1);
    div_start(M_REMU, 32'd9, 32'd0, "remu_by0", 32'd9);
    div_finish("remu_by0", 1);
    div_start(M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'h8000_0000);
    div_finish("div_ovf", 1);

    // Abort with cleare at cycle 10, then a fresh divide
    @(posedge clk); #1;
    set_mdu(M_DIV, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1 cleare = 1'b1;
    @(negedge clk);
    chk("clear_busy", 32'(mdu_busye), 32'd0);
    @(posedge clk); #1;
    cleare = 1'b0;
    set_mdu(M_DIVU, 32'd9, 32'd3);
    expect_val("divu_after_clear", 32'd3);
    div_finish("divu_after_clear", 33);

    // Abort with reset at cycle 10, then a fresh divide
    @(posedge clk); #1;
    set_mdu(M_DIV, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_abort_busy", 32'(mdu_busye), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_mdu(M_DIVU, 32'd9, 32'd3);
    expect_val("divu_after_reset", 32'd3);
    div_finish("divu_after_reset", 33);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
